prog_loader: RTL and testbench

- Upstream stage of the cpu core: receives a program as a byte stream over a valid/ready handshake and assembles 32-bit instruction words.
- Presents the words as the flat RAM image the cpu consumes, with word i at bits [(i+1)*32-1 -: 32].
- Holds the cpu in reset until a complete, checksum-verified image is loaded.
- Replaces the bench-side hex-file flattening with real hardware.

---
 rtl/prog_loader_pkg.sv | 21 ++
 rtl/prog_loader_word_assembler.sv | 39 +++
 rtl/prog_loader.sv | 135 +++++++++++++
 tb/tb_prog_loader.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/prog_loader_pkg.sv
// Shared definitions for the program loader: state encoding, word geometry
// and the length-header legality check.
package prog_loader_pkg;

  localparam int BYTES_PER_WORD = 4;
  localparam int WORD_W         = 32;

  typedef enum logic [2:0] {
    ST_LEN   = 3'd0,
    ST_DATA  = 3'd1,
    ST_CSUM  = 3'd2,
    ST_DONE  = 3'd3,
    ST_ERROR = 3'd4
  } state_t;

  // A length header is usable only if it names at least one word and fits the image.
  function automatic logic len_ok(input logic [7:0] n, input logic [7:0] max_words);
    return (n != 8'd0) && (n <= max_words);
  endfunction

endpackage

// File: rtl/prog_loader_word_assembler.sv
// Collects four stream bytes, MSB first, into one 32-bit word. The completed
// word is presented combinationally together with the 4th byte so the parent
// can commit it on the same edge that accepts that byte.
module word_assembler
  import prog_loader_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_restart,
  input  logic        i_accept,
  input  logic [7:0]  i_data,
  output logic [31:0] o_word,
  output logic        o_word_valid
);

  logic [23:0] r_shift;
  logic [1:0]  r_idx;

  // Shift accepted bytes in; the index wraps naturally after the 4th byte.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_shift <= '0;
      r_idx   <= '0;
    end else if (i_restart) begin
      r_shift <= '0;
      r_idx   <= '0;
    end else if (i_accept) begin
      r_shift <= {r_shift[15:0], i_data};
      r_idx   <= r_idx + 2'd1;
    end
  end

  // Three held bytes plus the byte being accepted form the finished word.
  always_comb begin
    o_word       = {r_shift, i_data};
    o_word_valid = i_accept && (r_idx == 2'(BYTES_PER_WORD - 1));
  end

endmodule

// File: rtl/prog_loader.sv
// Program loader: parses a length / data / checksum byte stream into a flat
// RAM image and holds the cpu in reset until the image verifies.
//
// state    | meaning
// ST_LEN   | waiting for the length header
// ST_DATA  | receiving N*4 data bytes
// ST_CSUM  | waiting for the checksum byte
// ST_DONE  | image verified, cpu released
// ST_ERROR | bad length or checksum, cpu held
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int RAM_SIZE = 16
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  input  logic                       i_restart,
  input  logic                       i_in_valid,
  input  logic [7:0]                 i_in_data,
  output logic                       o_in_ready,
  output logic [RAM_SIZE*WORD_W-1:0] o_ram,
  output logic                       o_cpu_reset,
  output logic                       o_done,
  output logic                       o_error,
  output logic [7:0]                 o_words_loaded
);

  localparam logic [7:0] C_MAX_WORDS = 8'(RAM_SIZE);

  state_t                     r_state, w_state_nxt;
  logic [RAM_SIZE*WORD_W-1:0] r_ram;
  logic [7:0]                 r_words_loaded;
  logic [7:0]                 r_len;
  logic [7:0]                 r_sum;
  logic                       r_done, r_error, r_cpu_reset;

  logic        w_accept;
  logic        w_asm_accept;
  logic [31:0] w_word;
  logic        w_word_valid;
  logic        w_last_word;

  // in_ready is decoded from state only, so in_valid never reaches it.
  always_comb begin
    o_in_ready   = (r_state == ST_LEN) || (r_state == ST_DATA) || (r_state == ST_CSUM);
    w_accept     = i_in_valid && o_in_ready && !i_restart;
    w_asm_accept = w_accept && (r_state == ST_DATA);
    w_last_word  = w_word_valid && (r_words_loaded == r_len - 8'd1);
  end

  word_assembler u_asm (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_restart    (i_restart),
    .i_accept     (w_asm_accept),
    .i_data       (i_in_data),
    .o_word       (w_word),
    .o_word_valid (w_word_valid)
  );

  // State register.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) r_state <= ST_LEN;
    else          r_state <= w_state_nxt;
  end

  // Next-state decode; restart overrides any byte acceptance.
  always_comb begin
    w_state_nxt = r_state;
    if (i_restart) begin
      w_state_nxt = ST_LEN;
    end else begin
      case (r_state)
        ST_LEN:  if (w_accept) w_state_nxt = len_ok(i_in_data, C_MAX_WORDS) ? ST_DATA : ST_ERROR;
        ST_DATA: if (w_last_word) w_state_nxt = ST_CSUM;
        ST_CSUM: if (w_accept) w_state_nxt = (i_in_data == r_sum) ? ST_DONE : ST_ERROR;
        default: w_state_nxt = r_state;
      endcase
    end
  end

  // Image, counters and registered status flags.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_ram          <= '0;
      r_words_loaded <= '0;
      r_len          <= '0;
      r_sum          <= '0;
      r_done         <= 1'b0;
      r_error        <= 1'b0;
      r_cpu_reset    <= 1'b1;
    end else if (i_restart) begin
      r_ram          <= '0;
      r_words_loaded <= '0;
      r_len          <= '0;
      r_sum          <= '0;
      r_done         <= 1'b0;
      r_error        <= 1'b0;
      r_cpu_reset    <= 1'b1;
    end else if (w_accept) begin
      case (r_state)
        ST_LEN: begin
          r_len <= i_in_data;
          r_sum <= '0;
          if (!len_ok(i_in_data, C_MAX_WORDS)) r_error <= 1'b1;
        end
        ST_DATA: begin
          r_sum <= r_sum + i_in_data;
          if (w_word_valid) begin
            for (int k = 0; k < RAM_SIZE; k++) begin
              if (r_words_loaded == 8'(k)) r_ram[k*WORD_W +: WORD_W] <= w_word;
            end
            r_words_loaded <= r_words_loaded + 8'd1;
          end
        end
        ST_CSUM: begin
          if (i_in_data == r_sum) begin
            r_done      <= 1'b1;
            r_cpu_reset <= 1'b0;
          end else begin
            r_error <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_ram          = r_ram;
  assign o_words_loaded = r_words_loaded;
  assign o_done         = r_done;
  assign o_error        = r_error;
  assign o_cpu_reset    = r_cpu_reset;

endmodule

// File: tb/tb_prog_loader.sv
// Directed and randomized checks for prog_loader against a simple image model.
module tb_prog_loader;

  localparam int RS = 16;
  localparam int IW = RS * 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          restart = 1'b0;
  logic          in_valid = 1'b0;
  logic [7:0]    in_data = 8'h00;
  logic          in_ready;
  logic [IW-1:0] ram;
  logic          cpu_reset, done, error;
  logic [7:0]    words_loaded;

  int n_chk = 0;
  int n_err = 0;

  logic [31:0] tw [RS];
  int          tn;

  prog_loader #(.RAM_SIZE(RS)) dut (
    .i_clk          (clk),
    .i_reset        (rst_n),
    .i_restart      (restart),
    .i_in_valid     (in_valid),
    .i_in_data      (in_data),
    .o_in_ready     (in_ready),
    .o_ram          (ram),
    .o_cpu_reset    (cpu_reset),
    .o_done         (done),
    .o_error        (error),
    .o_words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [IW-1:0] obs, input logic [IW-1:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one byte and wait (bounded) for the edge that accepts it.
  task automatic send_byte(input logic [7:0] b, input logic gap);
    logic rdy;
    int   budget;
    in_valid = 1'b1;
    in_data  = b;
    budget   = 0;
    do begin
      rdy = in_ready;
      tick();
      budget++;
    end while (!rdy && budget < 20);
    if (!rdy) begin
      n_chk++;
      n_err++;
      $error("FAIL send_timeout: observed not-ready expected ready");
    end
    in_valid = 1'b0;
    if (gap) tick();
  endtask

  task automatic pulse_restart();
    restart = 1'b1;
    tick();
    restart = 1'b0;
  endtask

  function automatic logic [7:0] model_sum();
    int s = 0;
    for (int i = 0; i < tn; i++)
      s += tw[i][31:24] + tw[i][23:16] + tw[i][15:8] + tw[i][7:0];
    return 8'(s);
  endfunction

  function automatic logic [IW-1:0] model_image();
    logic [IW-1:0] img = '0;
    for (int i = 0; i < tn; i++) img[i*32 +: 32] = tw[i];
    return img;
  endfunction

  // Stream the current tn/tw program, optionally with a corrupted checksum.
  task automatic send_program(input logic bad_csum, input logic gaps);
    logic [7:0] cs;
    send_byte(8'(tn), gaps);
    for (int i = 0; i < tn; i++)
      for (int j = 3; j >= 0; j--) send_byte(tw[i][j*8 +: 8], gaps);
    cs = model_sum();
    if (bad_csum) cs = cs + 8'd1;
    send_byte(cs, gaps);
  endtask

  task automatic set_nominal();
    tn = 2;
    tw[0] = 32'h12345678;
    tw[1] = 32'hDEADBEEF;
  endtask

  initial begin
    logic ok;
    // Reset state
    #12;
    check("rst_ram", ram, '0);
    check("rst_cpu_reset", IW'(cpu_reset), IW'(1));
    check("rst_done", IW'(done), IW'(0));
    check("rst_error", IW'(error), IW'(0));
    check("rst_words", IW'(words_loaded), IW'(0));
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("rst_ready", IW'(in_ready), IW'(1));

    // Nominal load
    set_nominal();
    check("nom_sum_model", IW'(model_sum()), IW'(8'h4C));
    send_program(1'b0, 1'b0);
    check("nom_ram", ram, model_image());
    check("nom_words", IW'(words_loaded), IW'(2));
    check("nom_done", IW'(done), IW'(1));
    check("nom_cpu_reset", IW'(cpu_reset), IW'(0));
    check("nom_ready", IW'(in_ready), IW'(0));

    // Bad checksum
    pulse_restart();
    check("rs_done_clr", IW'(done), IW'(0));
    send_program(1'b1, 1'b0);
    check("badcs_error", IW'(error), IW'(1));
    check("badcs_cpu_reset", IW'(cpu_reset), IW'(1));
    check("badcs_ready", IW'(in_ready), IW'(0));
    check("badcs_words", IW'(words_loaded), IW'(2));
    check("badcs_done", IW'(done), IW'(0));

    // Bad length headers
    pulse_restart();
    check("rs_ram_clr", ram, '0);
    check("rs_err_clr", IW'(error), IW'(0));
    send_byte(8'h00, 1'b0);
    check("len0_error", IW'(error), IW'(1));
    check("len0_ready", IW'(in_ready), IW'(0));
    pulse_restart();
    send_byte(8'h11, 1'b0);
    check("len17_error", IW'(error), IW'(1));
    check("len17_ram", ram, '0);
    check("len17_words", IW'(words_loaded), IW'(0));

    // Backpressure / gaps: idle cycle after every byte
    pulse_restart();
    send_byte(8'h02, 1'b1);
    for (int j = 3; j >= 0; j--) send_byte(tw[0][j*8 +: 8], 1'b1);
    check("gap_words_mid", IW'(words_loaded), IW'(1));
    for (int j = 3; j >= 1; j--) send_byte(tw[1][j*8 +: 8], 1'b1);
    check("gap_partial_hidden", ram, IW'(tw[0]));
    send_byte(tw[1][7:0], 1'b1);
    send_byte(model_sum(), 1'b1);
    check("gap_ram", ram, model_image());
    check("gap_words", IW'(words_loaded), IW'(2));
    check("gap_done", IW'(done), IW'(1));

    // Reset mid-load after byte 5
    pulse_restart();
    send_byte(8'h02, 1'b0);
    for (int j = 3; j >= 0; j--) send_byte(tw[0][j*8 +: 8], 1'b0);
    check("mid_words_pre", IW'(words_loaded), IW'(1));
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_ram", ram, '0);
    check("mid_rst_words", IW'(words_loaded), IW'(0));
    check("mid_rst_cpu_reset", IW'(cpu_reset), IW'(1));
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("mid_rst_ready", IW'(in_ready), IW'(1));
    send_program(1'b0, 1'b0);
    check("reload_ram", ram, model_image());
    check("reload_done", IW'(done), IW'(1));

    // Restart after DONE with in_valid held high
    in_valid = 1'b1;
    in_data  = 8'h02;
    restart  = 1'b1;
    tick();
    restart  = 1'b0;
    in_data  = 8'h01;
    check("rsd_done", IW'(done), IW'(0));
    check("rsd_ram", ram, '0);
    check("rsd_cpu_reset", IW'(cpu_reset), IW'(1));
    tick();
    in_valid = 1'b0;
    tn = 1;
    tw[0] = 32'hAABBCCDD;
    for (int j = 3; j >= 0; j--) send_byte(tw[0][j*8 +: 8], 1'b0);
    send_byte(model_sum(), 1'b0);
    check("rsd_hdr_ram", ram, model_image());
    check("rsd_hdr_done", IW'(done), IW'(1));
    check("rsd_hdr_words", IW'(words_loaded), IW'(1));

    // Randomized loads
    for (int it = 0; it < 8; it++) begin
      logic bad, gaps;
      pulse_restart();
      tn   = int'($urandom_range(1, RS));
      bad  = ($urandom_range(0, 3) == 0);
      gaps = $urandom_range(0, 1) == 1;
      for (int i = 0; i < RS; i++) tw[i] = $urandom;
      send_program(bad, gaps);
      ok = !bad;
      check("rnd_ram", ram, model_image());
      check("rnd_words", IW'(words_loaded), IW'(tn));
      check("rnd_done", IW'(done), IW'(ok));
      check("rnd_error", IW'(error), IW'(!ok));
      check("rnd_cpu_reset", IW'(cpu_reset), IW'(!ok));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
